// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified memory port.
// The CPU has fixed priority, except that after MAX_BURST consecutive CPU grants
// with the loader waiting, the loader gets the next slot.
// All memory-side controls are registered. One access takes an ISSUE cycle then
// a RESP cycle, and the next arbitration overlaps RESP.
//
// state | meaning
// IDLE  | no access in flight; arbitrate
// ISSUE | mem_read/mem_write strobe is presented to memory for one cycle
// RESP  | read data returns to the owner; arbitrate the next access
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,

    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              owner
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] burst_cnt;
    logic             arb_en;
    logic             cpu_win;
    logic             ldr_win;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, arbitration and response qualifiers.
    // Grants are gated by reset so that no request is accepted while it is
    // asserted, even though the FSM is already sitting in IDLE.
    always_comb begin
        state_next = state;
        arb_en     = 1'b0;
        cpu_win    = 1'b0;
        ldr_win    = 1'b0;
        cpu_rvalid = 1'b0;
        ldr_rvalid = 1'b0;

        case (state)
            IDLE: begin
                arb_en = ~reset;
            end
            ISSUE: begin
                state_next = RESP;
            end
            RESP: begin
                arb_en     = ~reset;
                cpu_rvalid = ~owner;
                ldr_rvalid = owner;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (arb_en) begin
            cpu_win = cpu_req & ~((burst_cnt == BURST_LIMIT) & ldr_req);
            ldr_win = ldr_req & ~cpu_win;
        end

        if (state == IDLE || state == RESP) begin
            state_next = (cpu_win | ldr_win) ? ISSUE : IDLE;
        end
    end

    assign cpu_gnt   = cpu_win;
    assign ldr_gnt   = ldr_win;
    assign cpu_rdata = mem_rdata;
    assign ldr_rdata = mem_rdata;

    // The RESP term can never be 1 (cpu_rvalid is high whenever the CPU owns RESP);
    // it is kept so the stall equation reads the same as the sequencer's view of it.
    assign cpu_stall = (cpu_req & ~cpu_gnt)
                     | ((state == ISSUE) & ~owner)
                     | ((state == RESP) & ~owner & ~cpu_rvalid);

    // Memory-side registers: load from the winner, strobe for exactly the ISSUE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            owner     <= 1'b0;
        end else if (cpu_win) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_read  <= ~cpu_we;
            mem_write <= cpu_we;
            owner     <= 1'b0;
        end else if (ldr_win) begin
            mem_addr  <= ldr_addr;
            mem_wdata <= ldr_wdata;
            mem_read  <= ~ldr_we;
            mem_write <= ldr_we;
            owner     <= 1'b1;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end
    end

    // Consecutive CPU grants taken while the loader is waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
        end else if (arb_en) begin
            if (!ldr_req || ldr_win) begin
                burst_cnt <= '0;
            end else if (cpu_win && burst_cnt != BURST_LIMIT) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small synchronous memory model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid, cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ldr_req, ldr_we;
    logic [ADDR_W-1:0] ldr_addr;
    logic [DATA_W-1:0] ldr_wdata;
    logic              ldr_gnt, ldr_rvalid;
    logic [DATA_W-1:0] ldr_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_rdata;
    logic              owner;

    logic              pre_en;
    logic [8:0]        pre_addr;
    logic [DATA_W-1:0] pre_data;
    logic [DATA_W-1:0] mem [0:511];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    // Synchronous memory: one-cycle read latency, preload port for the bench
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (mem_write) mem[mem_addr[8:0]] <= mem_wdata;
        if (mem_read) mem_rdata <= mem[mem_addr[8:0]];
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
        pre_en = 1'b1; pre_addr = 9'h040; pre_data = 32'hDEADBEEF;
        next_cycle();
        @(negedge clk);
        checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++;
            $display("FAIL reset_strobes: rd=%b wr=%b expected 0 0", mem_read, mem_write); end
        checks++; if (cpu_gnt !== 1'b0 || ldr_gnt !== 1'b0) begin errors++;
            $display("FAIL reset_gnt: cpu=%b ldr=%b expected 0 0", cpu_gnt, ldr_gnt); end
        checks++; if (cpu_rvalid !== 1'b0 || ldr_rvalid !== 1'b0) begin errors++;
            $display("FAIL reset_rvalid: cpu=%b ldr=%b expected 0 0", cpu_rvalid, ldr_rvalid); end
        checks++; if (owner !== 1'b0 || cpu_stall !== 1'b1) begin errors++;
            $display("FAIL reset_owner_stall: owner=%b stall=%b expected 0 1", owner, cpu_stall); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin errors++;
            $display("FAIL reset_mem_regs: addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
        next_cycle();
        reset = 1'b0;
        pre_en = 1'b0;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin errors++;
            $display("FAIL reset_first_grant: cpu=%b ldr=%b expected 1 0", cpu_gnt, ldr_gnt); end
        next_cycle();
        cpu_req = 1'b0; ldr_req = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin errors++;
            $display("FAIL cpu_read_c0: gnt=%b stall=%b expected 1 0", cpu_gnt, cpu_stall); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h40) begin errors++;
            $display("FAIL cpu_read_issue: rd=%b wr=%b addr=%h expected 1 0 00000040", mem_read, mem_write, mem_addr); end
        checks++; if (cpu_stall !== 1'b1 || cpu_gnt !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL cpu_read_c1: stall=%b gnt=%b rvalid=%b expected 1 0 0", cpu_stall, cpu_gnt, cpu_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL cpu_read_resp: rvalid=%b rdata=%h expected 1 deadbeef", cpu_rvalid, cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0 || ldr_rvalid !== 1'b0 || mem_read !== 1'b0) begin errors++;
            $display("FAIL cpu_read_c2: stall=%b ldr_rvalid=%b rd=%b expected 0 0 0", cpu_stall, ldr_rvalid, mem_read); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL cpu_read_after: rvalid=%b expected 0", cpu_rvalid); end
        next_cycle();
    endtask

    task automatic test_ldr_write();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 32'h100; ldr_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (ldr_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++;
            $display("FAIL ldr_write_gnt: ldr=%b cpu=%b expected 1 0", ldr_gnt, cpu_gnt); end
        next_cycle();
        ldr_req = 1'b0;
        @(negedge clk);
        checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h100 || mem_wdata !== 32'h12345678) begin errors++;
            $display("FAIL ldr_write_issue: wr=%b rd=%b addr=%h wdata=%h expected 1 0 00000100 12345678", mem_write, mem_read, mem_addr, mem_wdata); end
        checks++; if (owner !== 1'b1 || ldr_rvalid !== 1'b0 || cpu_stall !== 1'b0) begin errors++;
            $display("FAIL ldr_write_c1: owner=%b rvalid=%b stall=%b expected 1 0 0", owner, ldr_rvalid, cpu_stall); end
        next_cycle();
        @(negedge clk);
        checks++; if (ldr_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || mem_write !== 1'b0) begin errors++;
            $display("FAIL ldr_write_resp: ldr_rvalid=%b cpu_rvalid=%b wr=%b expected 1 0 0", ldr_rvalid, cpu_rvalid, mem_write); end
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL ldr_write_rb_gnt: gnt=%b expected 1", cpu_gnt); end
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin errors++;
            $display("FAIL ldr_write_readback: rvalid=%b rdata=%h expected 1 12345678", cpu_rvalid, cpu_rdata); end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_simultaneous();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h100;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || ldr_gnt !== 1'b0) begin errors++;
            $display("FAIL simul_c0: cpu=%b ldr=%b expected 1 0", cpu_gnt, ldr_gnt); end
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b0 || ldr_gnt !== 1'b0 || mem_read !== 1'b1 || owner !== 1'b0) begin errors++;
            $display("FAIL simul_c1: cpu=%b ldr=%b rd=%b owner=%b expected 0 0 1 0", cpu_gnt, ldr_gnt, mem_read, owner); end
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || ldr_gnt !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL simul_c2: cpu_rvalid=%b ldr_gnt=%b rdata=%h expected 1 1 deadbeef", cpu_rvalid, ldr_gnt, cpu_rdata); end
        next_cycle();
        ldr_req = 1'b0;
        @(negedge clk);
        checks++; if (owner !== 1'b1 || mem_read !== 1'b1 || mem_addr !== 32'h100 || cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL simul_c3: owner=%b rd=%b addr=%h cpu_rvalid=%b expected 1 1 00000100 0", owner, mem_read, mem_addr, cpu_rvalid); end
        next_cycle();
        @(negedge clk);
        checks++; if (ldr_rvalid !== 1'b1 || cpu_rvalid !== 1'b0 || ldr_rdata !== 32'h12345678) begin errors++;
            $display("FAIL simul_c4: ldr_rvalid=%b cpu_rvalid=%b rdata=%h expected 1 0 12345678", ldr_rvalid, cpu_rvalid, ldr_rdata); end
        next_cycle();
        next_cycle();
    endtask

    task automatic test_burst_limit();
        bit exp_ldr;
        bit prev_ldr;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 32'h100;
        prev_ldr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                exp_ldr = ((c / 2) % 5 == 4);
                checks++; if (cpu_gnt !== !exp_ldr || ldr_gnt !== exp_ldr) begin errors++;
                    $display("FAIL burst_grant[%0d]: cpu=%b ldr=%b expected %b %b", c / 2, cpu_gnt, ldr_gnt, !exp_ldr, exp_ldr); end
                checks++; if (cpu_stall !== exp_ldr) begin errors++;
                    $display("FAIL burst_stall_arb[%0d]: stall=%b expected %b", c / 2, cpu_stall, exp_ldr); end
                if (c > 0) begin
                    checks++; if (cpu_rvalid !== !prev_ldr || ldr_rvalid !== prev_ldr) begin errors++;
                        $display("FAIL burst_rvalid[%0d]: cpu=%b ldr=%b expected %b %b", c / 2, cpu_rvalid, ldr_rvalid, !prev_ldr, prev_ldr); end
                end
                prev_ldr = exp_ldr;
            end else begin
                checks++; if (cpu_gnt !== 1'b0 || ldr_gnt !== 1'b0 || mem_read !== 1'b1 || owner !== prev_ldr) begin errors++;
                    $display("FAIL burst_issue[%0d]: cpu=%b ldr=%b rd=%b owner=%b expected 0 0 1 %b", c / 2, cpu_gnt, ldr_gnt, mem_read, owner, prev_ldr); end
                checks++; if (cpu_stall !== 1'b1) begin errors++;
                    $display("FAIL burst_stall_issue[%0d]: stall=%b expected 1", c / 2, cpu_stall); end
            end
            next_cycle();
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid_issue();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1) begin errors++;
            $display("FAIL rst_mid_gnt: gnt=%b expected 1", cpu_gnt); end
        next_cycle();
        cpu_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++; if (mem_read !== 1'b1) begin errors++;
            $display("FAIL rst_mid_issue: rd=%b expected 1", mem_read); end
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0 || cpu_stall !== 1'b0) begin errors++;
            $display("FAIL rst_mid_after: rvalid=%b rd=%b wr=%b stall=%b expected 0 0 0 0", cpu_rvalid, mem_read, mem_write, cpu_stall); end
        next_cycle();
        cpu_req = 1'b1;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0) begin errors++;
            $display("FAIL rst_mid_regrant: gnt=%b rvalid=%b expected 1 0", cpu_gnt, cpu_rvalid); end
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL rst_mid_reissue: rvalid=%b rdata=%h expected 1 deadbeef", cpu_rvalid, cpu_rdata); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_simultaneous();
        test_burst_limit();
        test_reset_mid_issue();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
